// File: rtl/snoopy_pkg.sv
// Shared constants for the Snoopy sprite blocks.
//
// Holds the visible screen bounds, the sprite size, the colour constants
// (background, solid sprite, transparent ROM colour), the drawer state
// encoding, and the sprite bitmap table. The horizontal and vertical
// position FSMs use the same bounds.
//
// The sprite bitmap sits here as a constant function. It is indexed by
// row * SPRITE_W + col. The ROM sub-module reads it through a register.
package snoopy_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;

    localparam logic [2:0] BG_COLOUR          = 3'b000;
    localparam logic [2:0] SPRITE_COLOUR      = 3'b111;
    localparam logic [2:0] TRANSPARENT_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        DRAWER_IDLE  = 2'd0,
        DRAWER_ERASE = 2'd1,
        DRAWER_DRAW  = 2'd2
    } drawer_state_e;

    // Sprite bitmap. Three corners are transparent. Every other entry has a
    // non-zero colour that changes along the traversal order, so a
    // misplaced pixel shows up.
    function automatic logic [2:0] sprite_rom_word(input int unsigned idx);
        logic [2:0] word;
        if (idx == 0 || idx == 7 || idx == 63) begin
            word = TRANSPARENT_COLOUR;
        end else begin
            word = 3'((idx % 7) + 1);
        end
        return word;
    endfunction

endpackage

// File: rtl/snoopy_sprite_drawer_if.sv
// Bundle between the sprite drawer and the blocks around it.
//
// Signals:
//   frame_tick  : single-cycle frame pulse, driven into the drawer
//   snoopy_x/y  : sprite top-left position from the position FSMs
//   vga_x/y     : pixel coordinate to the VGA adapter
//   vga_colour  : pixel colour
//   vga_plot    : write strobe
//   busy        : erase/draw pass in progress
//   debug_state : drawer FSM state, for observation only
//
// Handshake semantics: there is no back-pressure. The adapter must accept
// a pixel on every cycle where vga_plot is high. vga_x, vga_y and
// vga_colour are meaningful only in those cycles; otherwise they hold the
// last plotted pixel. frame_tick is only looked at while busy is low, and
// ticks that arrive while busy is high are dropped.
//
// Modports: master = the drawer, slave = the environment (position FSMs
// and VGA adapter).
interface snoopy_sprite_drawer_if;
    import snoopy_pkg::*;

    logic          frame_tick;
    logic [7:0]    snoopy_x;
    logic [6:0]    snoopy_y;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;
    logic          busy;
    drawer_state_e debug_state;

    modport master (
        input  frame_tick, snoopy_x, snoopy_y,
        output vga_x, vga_y, vga_colour, vga_plot, busy, debug_state
    );

    modport slave (
        output frame_tick, snoopy_x, snoopy_y,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, debug_state
    );

endinterface

// File: rtl/snoopy_sprite_rom.sv
// Sprite colour ROM with a registered read.
//
// The ROM is DEPTH x 3 bits. Its contents come from the package bitmap
// table, which is indexed by {row, col}. The colour appears one clock
// after addr is presented. The ROM has no reset, because the contents are
// constant.
//
// Ports:
//   clock  : system clock
//   addr   : {row, col} index
//   colour : registered colour read
module snoopy_sprite_rom
    import snoopy_pkg::*;
#(
    parameter int DEPTH = SPRITE_W * SPRITE_H,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    output logic [2:0]    colour
);

    always_ff @(posedge clock) begin
        colour <= sprite_rom_word(32'(addr));
    end

endmodule

// File: rtl/snoopy_sprite_drawer.sv
// Snoopy sprite drawer.
//
// On each frame tick the drawer snapshots Snoopy's (x, y) position. It then
// streams one pixel per cycle to the 160x120 VGA adapter. It first erases
// the rectangle at the previously drawn position, then draws the sprite at
// the new position. A tick at an unchanged position does nothing. The
// first pass after reset has no valid old position, so it draws without
// erasing.
//
// Ports:
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : snoopy_sprite_drawer_if.master. Carries frame_tick and
//           snoopy_x/y in, and vga_x/y/colour/plot, busy and debug_state
//           out.
//
// Timing (tick sampled in cycle T): busy is high from T+1. The first pixel
// is at T+2, and busy falls with the last pixel. Off-screen pixels keep
// their slot in the pass but are not plotted.
//
// Optional build macro SNOOPY_SPRITE_ROM_EN: the draw colour comes from
// snoopy_sprite_rom. Its registered read adds one pipeline stage, so the
// first pixel moves to T+3 and busy stretches by one cycle. Draw pixels
// whose ROM colour is transparent are not plotted. Erase still clears the
// full rectangle.
module snoopy_sprite_drawer
    import snoopy_pkg::*;
#(
    parameter int         SPRITE_W      = snoopy_pkg::SPRITE_W,
    parameter int         SPRITE_H      = snoopy_pkg::SPRITE_H,
    parameter int         SCREEN_W      = snoopy_pkg::SCREEN_W,
    parameter int         SCREEN_H      = snoopy_pkg::SCREEN_H,
    parameter logic [2:0] BG_COLOUR     = snoopy_pkg::BG_COLOUR,
    parameter logic [2:0] SPRITE_COLOUR = snoopy_pkg::SPRITE_COLOUR
) (
    input logic                   clock,
    input logic                   reset,
    snoopy_sprite_drawer_if.master bus
);

    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);
    localparam logic [8:0]       X_LIMIT  = 9'(SCREEN_W);
    localparam logic [7:0]       Y_LIMIT  = 8'(SCREEN_H);

    drawer_state_e state, next_state;

    logic [7:0]       new_x, old_x;
    logic [6:0]       new_y, old_y;
    logic             old_valid;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic             latch_pos;
    logic             commit_pos;
    logic             cnt_clear;
    logic             cnt_adv;
    logic             last_pix;

    logic [7:0]       base_x;
    logic [6:0]       base_y;
    logic [8:0]       pix_x;
    logic [7:0]       pix_y;
    logic             pix_on;
    logic [2:0]       pix_colour;

    logic             busy_r;
    logic             plot_r;
    logic [7:0]       x_r;
    logic [6:0]       y_r;
    logic [2:0]       colour_r;

    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DRAWER_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        latch_pos  = 1'b0;
        commit_pos = 1'b0;
        cnt_clear  = 1'b0;
        cnt_adv    = 1'b0;
        unique case (state)
            DRAWER_IDLE: begin
                if (bus.frame_tick) begin
                    latch_pos = 1'b1;
                    cnt_clear = 1'b1;
                    // Compare against the live inputs. They are the values
                    // being latched on this same edge.
                    if (old_valid && bus.snoopy_x == old_x && bus.snoopy_y == old_y) begin
                        next_state = DRAWER_IDLE;
                    end else if (old_valid) begin
                        next_state = DRAWER_ERASE;
                    end else begin
                        next_state = DRAWER_DRAW;
                    end
                end
            end
            DRAWER_ERASE: begin
                cnt_adv = 1'b1;
                if (last_pix) begin
                    cnt_clear  = 1'b1;
                    next_state = DRAWER_DRAW;
                end
            end
            DRAWER_DRAW: begin
                cnt_adv = 1'b1;
                if (last_pix) begin
                    cnt_clear  = 1'b1;
                    commit_pos = 1'b1;
                    next_state = DRAWER_IDLE;
                end
            end
            default: begin
                next_state = DRAWER_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Position registers and traversal counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            new_x     <= '0;
            new_y     <= '0;
            old_x     <= '0;
            old_y     <= '0;
            old_valid <= 1'b0;
            col       <= '0;
            row       <= '0;
        end else begin
            if (latch_pos) begin
                new_x <= bus.snoopy_x;
                new_y <= bus.snoopy_y;
            end
            if (commit_pos) begin
                old_x     <= new_x;
                old_y     <= new_y;
                old_valid <= 1'b1;
            end
            // Clear wins over advance, so the erase-to-draw handover
            // restarts at pixel (0, 0).
            if (cnt_clear) begin
                col <= '0;
                row <= '0;
            end else if (cnt_adv) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Current pixel. The coordinates are widened so that a sprite hanging
    // off the right or bottom edge is clipped instead of wrapping around.
    // ------------------------------------------------------------------
    always_comb begin
        base_x     = (state == DRAWER_ERASE) ? old_x : new_x;
        base_y     = (state == DRAWER_ERASE) ? old_y : new_y;
        pix_x      = 9'(base_x) + 9'(col);
        pix_y      = 8'(base_y) + 8'(row);
        pix_on     = (state != DRAWER_IDLE) && (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);
        pix_colour = (state == DRAWER_ERASE) ? BG_COLOUR : SPRITE_COLOUR;
    end

`ifdef SNOOPY_SPRITE_ROM_EN
    // ------------------------------------------------------------------
    // ROM build: stage 1 lines up the pixel with the registered ROM read.
    // Stage 2 applies transparency and drives the adapter.
    // ------------------------------------------------------------------
    logic       s1_on;
    logic       s1_draw;
    logic [7:0] s1_x;
    logic [6:0] s1_y;
    logic [2:0] s1_colour;
    logic [2:0] rom_colour;
    logic       s2_plot;
    logic [2:0] s2_colour;

    snoopy_sprite_rom #(
        .DEPTH (SPRITE_W * SPRITE_H),
        .AW    (ROW_W + COL_W)
    ) u_rom (
        .clock  (clock),
        .addr   ({row, col}),
        .colour (rom_colour)
    );

    always_comb begin
        s2_colour = s1_draw ? rom_colour : s1_colour;
        s2_plot   = s1_on && !(s1_draw && rom_colour == TRANSPARENT_COLOUR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_on     <= 1'b0;
            s1_draw   <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_colour <= '0;
            busy_r    <= 1'b0;
            plot_r    <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            colour_r  <= '0;
        end else begin
            s1_on     <= pix_on;
            s1_draw   <= (state == DRAWER_DRAW);
            s1_x      <= pix_x[7:0];
            s1_y      <= pix_y[6:0];
            s1_colour <= pix_colour;
            // Stage 1 is occupied next cycle whenever a pixel is issued
            // now, so busy covers the extra pipeline slot.
            busy_r    <= (next_state != DRAWER_IDLE) || (state != DRAWER_IDLE);
            plot_r    <= s2_plot;
            if (s2_plot) begin
                x_r      <= s1_x;
                y_r      <= s1_y;
                colour_r <= s2_colour;
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Solid build: a single output register stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r   <= 1'b0;
            plot_r   <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            colour_r <= '0;
        end else begin
            busy_r <= (next_state != DRAWER_IDLE);
            plot_r <= pix_on;
            if (pix_on) begin
                x_r      <= pix_x[7:0];
                y_r      <= pix_y[6:0];
                colour_r <= pix_colour;
            end
        end
    end
`endif

    assign bus.vga_x       = x_r;
    assign bus.vga_y       = y_r;
    assign bus.vga_colour  = colour_r;
    assign bus.vga_plot    = plot_r;
    assign bus.busy        = busy_r;
    assign bus.debug_state = state;

endmodule

// File: tb/tb_snoopy_sprite_drawer.sv
// Testbench for snoopy_sprite_drawer.
//
// The reference model keeps the last drawn position. For each tick it lists
// the expected pixels as (cycle, x, y, colour), using nested loops over the
// sprite rectangle and clipping against the screen. Each observed plot must
// match the front of that list, in both content and cycle. Between plots
// the adapter outputs must hold the last expected pixel.
module tb_snoopy_sprite_drawer;
    import snoopy_pkg::*;

    localparam int W = 8;
    localparam int H = 8;
`ifdef SNOOPY_SPRITE_ROM_EN
    localparam int LAT       = 3;
    localparam int ROM_EXTRA = 1;
`else
    localparam int LAT       = 2;
    localparam int ROM_EXTRA = 0;
`endif
    localparam int WIN = 2 * W * H + LAT + 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    snoopy_sprite_drawer_if bus ();

    snoopy_sprite_drawer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [25:0] exp_q[$];      // {cycle[7:0], x[7:0], y[6:0], colour[2:0]}
    logic [17:0] last_pix;      // {x, y, colour} of the last expected plot

    // Reference model state
    bit m_valid;
    int m_x;
    int m_y;
    int exp_busy;
    int exp_plots;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic void add_pixel(input int k, input int px, input int py,
                                      input logic [2:0] c, input bit draw, input int idx);
        logic [2:0] col_v;
        col_v = c;
        if (px >= SCREEN_W || py >= SCREEN_H) return;
`ifdef SNOOPY_SPRITE_ROM_EN
        if (draw) begin
            col_v = sprite_rom_word(idx);
            if (col_v == 3'b000) return;
        end
`else
        if (draw && idx < 0) return;
`endif
        exp_q.push_back({8'(k), 8'(px), 7'(py), col_v});
    endfunction

    // Build the expected pixel list for a tick at (x, y).
    task automatic model_pass(input int x, input int y);
        int n;
        exp_q.delete();
        n = 0;
        if (m_valid && x == m_x && y == m_y) begin
            exp_busy = 0;
        end else begin
            if (m_valid) begin
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++) begin
                        add_pixel(LAT + n, m_x + c, m_y + r, BG_COLOUR, 1'b0, r * W + c);
                        n++;
                    end
            end
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    add_pixel(LAT + n, x + c, y + r, SPRITE_COLOUR, 1'b1, r * W + c);
                    n++;
                end
            m_x      = x;
            m_y      = y;
            m_valid  = 1'b1;
            exp_busy = n + ROM_EXTRA;
        end
        exp_plots = exp_q.size();
    endtask

    task automatic check_all_zero(input string name);
        check({name, " plot"}, 32'(bus.vga_plot), 32'd0);
        check({name, " busy"}, 32'(bus.busy), 32'd0);
        check({name, " xyc"}, 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
        check({name, " state"}, 32'(bus.debug_state), 32'(DRAWER_IDLE));
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset    = 1'b0;
        m_valid  = 1'b0;
        last_pix = '0;
    endtask

    // One tick at (x, y), then watch for a fixed window. Optionally inject a
    // second tick at cycle mid_tick, or assert reset at cycle reset_at.
    task automatic run_pass(input int x, input int y, input int mid_tick, input int reset_at,
                            output int n_plots, output int n_busy);
        logic [25:0] e;
        bit aborted;
        model_pass(x, y);
        n_plots = 0;
        n_busy  = 0;
        aborted = 1'b0;
        @(negedge clock);
        bus.frame_tick = 1'b1;
        bus.snoopy_x   = 8'(x);
        bus.snoopy_y   = 7'(y);
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.frame_tick = 1'b0;
                // Only the latched copy may be used from here on.
                bus.snoopy_x = 8'($urandom_range(0, 160));
                bus.snoopy_y = 7'($urandom_range(0, 127));
            end
            if (mid_tick > 0 && k == mid_tick) bus.frame_tick = 1'b1;
            if (mid_tick > 0 && k == mid_tick + 1) bus.frame_tick = 1'b0;

            if (reset_at > 0 && k == reset_at + 1) begin
                check_all_zero("mid-pass reset");
                reset = 1'b0;
                exp_q.delete();
                m_valid  = 1'b0;
                last_pix = '0;
                aborted  = 1'b1;
                break;
            end

            if (bus.busy) n_busy++;
            if (exp_busy > 0 && k == 1) check("busy rise", 32'(bus.busy), 32'd1);
            if (bus.vga_plot) begin
                n_plots++;
                if (exp_q.size() == 0) begin
                    check("unexpected plot", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'hffffffff);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel {cyc,x,y,c}",
                          32'({8'(k), bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(e));
                    last_pix = e[17:0];
                end
            end else begin
                check("hold xyc", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(last_pix));
            end

            if (reset_at > 0 && k == reset_at) reset = 1'b1;
        end
        if (!aborted) begin
            check("missing plots", 32'(exp_q.size()), 32'd0);
            check("busy length", 32'(n_busy), 32'(exp_busy));
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int x;
        int y;
        int mid_tick;
        int exp_plots;   // hand-computed for the solid build
        int exp_busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int np, nb, rx, ry;

        // Each row continues from the position left by the previous row.
        vecs[0] = '{x: 10,  y: 20,  mid_tick: 0,  exp_plots: 64,  exp_busy: 64};   // draw only
        vecs[1] = '{x: 11,  y: 20,  mid_tick: 0,  exp_plots: 128, exp_busy: 128};  // erase + draw
        vecs[2] = '{x: 11,  y: 20,  mid_tick: 0,  exp_plots: 0,   exp_busy: 0};    // unchanged
        vecs[3] = '{x: 30,  y: 50,  mid_tick: 10, exp_plots: 128, exp_busy: 128};  // tick mid-pass ignored
        vecs[4] = '{x: 159, y: 119, mid_tick: 0,  exp_plots: 65,  exp_busy: 128};  // corner clip
        vecs[5] = '{x: 160, y: 0,   mid_tick: 0,  exp_plots: 1,   exp_busy: 128};  // fully off right
        vecs[6] = '{x: 0,   y: 112, mid_tick: 0,  exp_plots: 64,  exp_busy: 128};  // bottom rows

        bus.frame_tick = 1'b0;
        bus.snoopy_x   = '0;
        bus.snoopy_y   = '0;
        m_valid  = 1'b0;
        last_pix = '0;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            run_pass(vecs[i].x, vecs[i].y, vecs[i].mid_tick, 0, np, nb);
`ifndef SNOOPY_SPRITE_ROM_EN
            check($sformatf("vec%0d plots", i), 32'(np), 32'(vecs[i].exp_plots));
`endif
            check($sformatf("vec%0d busy", i),
                  32'(nb), 32'(vecs[i].exp_busy + (vecs[i].exp_busy > 0 ? ROM_EXTRA : 0)));
        end

        // Reset during DRAW (the draw half starts at cycle 65), then draw only.
        run_pass(50, 60, 0, 80, np, nb);
        run_pass(40, 30, 0, 0, np, nb);
`ifndef SNOOPY_SPRITE_ROM_EN
        check("after reset plots", 32'(np), 32'd64);
`endif
        check("after reset busy", 32'(nb), 32'(64 + ROM_EXTRA));

        // Clipped draw-only pass: 4x4 visible pixels, full-length pass.
        do_reset();
        run_pass(156, 116, 0, 0, np, nb);
`ifndef SNOOPY_SPRITE_ROM_EN
        check("clip plots", 32'(np), 32'd16);
`endif
        check("clip busy", 32'(nb), 32'(64 + ROM_EXTRA));

        // Random positions, sometimes repeating the last one.
        for (int i = 0; i < 8; i++) begin
            if (m_valid && $urandom_range(0, 3) == 0) begin
                rx = m_x;
                ry = m_y;
            end else begin
                rx = $urandom_range(0, 160);
                ry = $urandom_range(0, 127);
            end
            run_pass(rx, ry, 0, 0, np, nb);
            check("random plot count", 32'(np), 32'(exp_plots));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
